mm_bram_row_loader: RTL and testbench

MM_BRAM_ROW_LOADER -- requirements
Module: mm_bram_row_loader

---
 rtl/mm_bram_pkg.sv | 17 +
 rtl/mm_bram_row_loader_if.sv | 29 ++
 rtl/mm_bram_row_loader_ctrl.sv | 122 ++++++++++++
 rtl/mm_bram_row_loader.sv | 79 +++++++
 tb/tb_mm_bram_row_loader.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_bram_pkg.sv
// Shared types for the matrix-multiply BRAM loader family.
// Holds the loader FSM state encoding used by the controller.
`ifndef MM_BRAM_PKG_SV
`define MM_BRAM_PKG_SV

package mm_bram_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        START = 2'd2,
        BUSY  = 2'd3
    } loader_state_e;

endpackage

`endif

// File: rtl/mm_bram_row_loader_if.sv
// Upstream and matrix-multiply handshake bundle for the row loader.
// The master side is the loader controller; the slave side is its peer.
`ifndef MM_BRAM_ROW_LOADER_IF_SV
`define MM_BRAM_ROW_LOADER_IF_SV

interface mm_bram_row_loader_if;

    logic in_val;
    logic in_rdy;
    logic mm_val;
    logic mm_rdy;

    modport master (
        input  in_val,
        input  mm_rdy,
        output in_rdy,
        output mm_val
    );

    modport slave (
        output in_val,
        output mm_rdy,
        input  in_rdy,
        input  mm_val
    );

endinterface

`endif

// File: rtl/mm_bram_row_loader_ctrl.sv
// Loader FSM with row/column position counters.
// Counter wraps use explicit compares so any ROW_NUM/LENGTH >= 2 works.
`ifndef MM_BRAM_ROW_LOADER_CTRL_SV
`define MM_BRAM_ROW_LOADER_CTRL_SV

module mm_bram_row_loader_ctrl
    import mm_bram_pkg::*;
#(
    parameter int ROW_NUM           = 32,
    parameter int LENGTH            = 32,
    parameter int ROW_ADDR_WIDTH    = 5,
    parameter int LENGTH_ADDR_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    mm_bram_row_loader_if.master         hs,
    output logic                         accept,
    output logic [ROW_ADDR_WIDTH-1:0]    row,
    output logic [LENGTH_ADDR_WIDTH-1:0] col
);

    localparam logic [ROW_ADDR_WIDTH-1:0]    ROW_LAST = ROW_ADDR_WIDTH'(ROW_NUM - 1);
    localparam logic [LENGTH_ADDR_WIDTH-1:0] COL_LAST = LENGTH_ADDR_WIDTH'(LENGTH - 1);
    localparam logic [ROW_ADDR_WIDTH-1:0]    ROW_ONE  = ROW_ADDR_WIDTH'(1);
    localparam logic [LENGTH_ADDR_WIDTH-1:0] COL_ONE  = LENGTH_ADDR_WIDTH'(1);

    loader_state_e                  state_r;
    loader_state_e                  state_nxt_s;
    logic [ROW_ADDR_WIDTH-1:0]      row_r;
    logic [ROW_ADDR_WIDTH-1:0]      row_nxt_s;
    logic [LENGTH_ADDR_WIDTH-1:0]   col_r;
    logic [LENGTH_ADDR_WIDTH-1:0]   col_nxt_s;
    logic                           busy_first_r;
    logic                           accept_s;
    logic                           last_elem_s;

    // Acceptance is decoded from the state register to keep in_rdy out of the path.
    assign accept_s    = hs.in_val && (state_r == LOAD);
    assign last_elem_s = (row_r == ROW_LAST) && (col_r == COL_LAST);

    assign accept = accept_s;
    assign row    = row_r;
    assign col    = col_r;

    // State, position counters and the first-BUSY-cycle marker
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= LOAD;
            row_r        <= {ROW_ADDR_WIDTH{1'b0}};
            col_r        <= {LENGTH_ADDR_WIDTH{1'b0}};
            busy_first_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            row_r        <= row_nxt_s;
            col_r        <= col_nxt_s;
            busy_first_r <= (state_r == START) && hs.mm_rdy;
        end
    end

    // Next position: column advances per element, row advances on column wrap
    always_comb begin
        row_nxt_s = row_r;
        col_nxt_s = col_r;
        if (accept_s) begin
            if (col_r == COL_LAST) begin
                col_nxt_s = {LENGTH_ADDR_WIDTH{1'b0}};
                if (row_r == ROW_LAST) begin
                    row_nxt_s = {ROW_ADDR_WIDTH{1'b0}};
                end else begin
                    row_nxt_s = row_r + ROW_ONE;
                end
            end else begin
                col_nxt_s = col_r + COL_ONE;
            end
        end else begin
            row_nxt_s = row_r;
            col_nxt_s = col_r;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt_s = state_r;
        hs.in_rdy   = 1'b0;
        hs.mm_val   = 1'b0;
        case (state_r)
            LOAD: begin
                hs.in_rdy = 1'b1;
                if (accept_s && last_elem_s) begin
                    state_nxt_s = FLUSH;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            FLUSH: begin
                state_nxt_s = START;
            end
            START: begin
                hs.mm_val = 1'b1;
                if (hs.mm_rdy) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = START;
                end
            end
            BUSY: begin
                // mm_rdy in the handshake's following cycle is still the old pulse
                if (!busy_first_r && hs.mm_rdy) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = LOAD;
            end
        endcase
    end

endmodule

`endif

// File: rtl/mm_bram_row_loader.sv
// Streams row-major elements into LENGTH parallel source banks and hands the
// completed matrix to the matrix-multiply engine via mm_val/mm_rdy.
`ifndef MM_BRAM_ROW_LOADER_SV
`define MM_BRAM_ROW_LOADER_SV

module mm_bram_row_loader
    import mm_bram_pkg::*;
#(
    parameter  int DATA_WIDTH        = 8,
    parameter  int ROW_NUM           = 32,
    parameter  int LENGTH            = 32,
    localparam int ROW_ADDR_WIDTH    = $clog2(ROW_NUM),
    localparam int LENGTH_ADDR_WIDTH = $clog2(LENGTH)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_val,
    output logic                             in_rdy,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic [DATA_WIDTH*LENGTH-1:0]     row_wrdata,
    output logic [ROW_ADDR_WIDTH*LENGTH-1:0] row_wraddr,
    output logic [LENGTH-1:0]                row_wr_en,
    output logic                             mm_val,
    input  logic                             mm_rdy
);

    localparam logic [LENGTH-1:0] EN_ONE = LENGTH'(1);

    logic                         accept_s;
    logic [ROW_ADDR_WIDTH-1:0]    row_s;
    logic [LENGTH_ADDR_WIDTH-1:0] col_s;
    logic [LENGTH-1:0]            wr_en_r;
    logic [DATA_WIDTH-1:0]        wr_data_r;
    logic [ROW_ADDR_WIDTH-1:0]    wr_addr_r;

    mm_bram_row_loader_if hs ();

    assign hs.in_val = in_val;
    assign hs.mm_rdy = mm_rdy;
    assign in_rdy    = hs.in_rdy;
    assign mm_val    = hs.mm_val;

    mm_bram_row_loader_ctrl #(
        .ROW_NUM           (ROW_NUM),
        .LENGTH            (LENGTH),
        .ROW_ADDR_WIDTH    (ROW_ADDR_WIDTH),
        .LENGTH_ADDR_WIDTH (LENGTH_ADDR_WIDTH)
    ) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .hs     (hs.master),
        .accept (accept_s),
        .row    (row_s),
        .col    (col_s)
    );

    // Write-port register: one cycle after acceptance, enable only the owning bank
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_r   <= {LENGTH{1'b0}};
            wr_data_r <= {DATA_WIDTH{1'b0}};
            wr_addr_r <= {ROW_ADDR_WIDTH{1'b0}};
        end else if (accept_s) begin
            wr_en_r   <= EN_ONE << col_s;
            wr_data_r <= in_data;
            wr_addr_r <= row_s;
        end else begin
            wr_en_r   <= {LENGTH{1'b0}};
        end
    end

    // Data and address are broadcast; the enable alone picks the bank.
    assign row_wrdata = {LENGTH{wr_data_r}};
    assign row_wraddr = {LENGTH{wr_addr_r}};
    assign row_wr_en  = wr_en_r;

endmodule

`endif

// File: tb/tb_mm_bram_row_loader.sv
// Directed self-checking bench for mm_bram_row_loader: a 4x4 instance for the
// main scenarios and a 3x3 instance for non-power-of-two wrapping.
module tb_mm_bram_row_loader;

    logic clk = 1'b0;
    logic reset;

    mm_bram_row_loader_if hs_a ();
    mm_bram_row_loader_if hs_b ();

    logic [7:0]  in_data_a;
    logic [31:0] wrdata_a;
    logic [7:0]  wraddr_a;
    logic [3:0]  wren_a;

    logic [7:0]  in_data_b;
    logic [23:0] wrdata_b;
    logic [5:0]  wraddr_b;
    logic [2:0]  wren_b;

    logic [7:0] bank_a [4][4];
    logic [7:0] bank_b [3][3];
    int wr_cnt_a = 0;
    int wr_cnt_b = 0;
    int checks   = 0;
    int failures = 0;
    int snap;

    always #5 clk = ~clk;

    mm_bram_row_loader #(.DATA_WIDTH(8), .ROW_NUM(4), .LENGTH(4)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .in_val     (hs_a.in_val),
        .in_rdy     (hs_a.in_rdy),
        .in_data    (in_data_a),
        .row_wrdata (wrdata_a),
        .row_wraddr (wraddr_a),
        .row_wr_en  (wren_a),
        .mm_val     (hs_a.mm_val),
        .mm_rdy     (hs_a.mm_rdy)
    );

    mm_bram_row_loader #(.DATA_WIDTH(8), .ROW_NUM(3), .LENGTH(3)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .in_val     (hs_b.in_val),
        .in_rdy     (hs_b.in_rdy),
        .in_data    (in_data_b),
        .row_wrdata (wrdata_b),
        .row_wraddr (wraddr_b),
        .row_wr_en  (wren_b),
        .mm_val     (hs_b.mm_val),
        .mm_rdy     (hs_b.mm_rdy)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d);
        hs_a.in_val = 1'b1;
        in_data_a   = d;
        for (int i = 0; i < 50; i++) begin
            if (hs_a.in_rdy) begin
                step();
                return;
            end
            step();
        end
        check_value("send_a_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_b(input logic [7:0] d);
        hs_b.in_val = 1'b1;
        in_data_b   = d;
        for (int i = 0; i < 50; i++) begin
            if (hs_b.in_rdy) begin
                step();
                return;
            end
            step();
        end
        check_value("send_b_timeout", 32'd0, 32'd1);
    endtask

    // Bank models fed from the write ports
    always @(negedge clk) begin
        if (wren_a != 4'b0000) begin
            check_value("wr_onehot_a", $countones(wren_a), 32'd1);
            for (int k = 0; k < 4; k++)
                if (wren_a[k]) bank_a[k][wraddr_a[k*2 +: 2]] <= wrdata_a[k*8 +: 8];
            wr_cnt_a <= wr_cnt_a + 1;
        end
        if (wren_b != 3'b000) begin
            check_value("wr_onehot_b", $countones(wren_b), 32'd1);
            for (int k = 0; k < 3; k++)
                if (wren_b[k] && wraddr_b[k*2 +: 2] < 2'd3) bank_b[k][wraddr_b[k*2 +: 2]] <= wrdata_b[k*8 +: 8];
            wr_cnt_b <= wr_cnt_b + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        hs_a.in_val = 1'b0; hs_a.mm_rdy = 1'b0; in_data_a = 8'h00;
        hs_b.in_val = 1'b0; hs_b.mm_rdy = 1'b0; in_data_b = 8'h00;
        for (int k = 0; k < 4; k++) for (int r = 0; r < 4; r++) bank_a[k][r] = 8'hFF;
        for (int k = 0; k < 3; k++) for (int r = 0; r < 3; r++) bank_b[k][r] = 8'hFF;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check_value("rst_in_rdy", hs_a.in_rdy, 32'd1);
        check_value("rst_mm_val", hs_a.mm_val, 32'd0);
        check_value("rst_wren", wren_a, 32'd0);
        check_value("rst_wrdata", wrdata_a, 32'd0);
        check_value("rst_wraddr", wraddr_a, 32'd0);

        // 16 back-to-back elements
        for (int i = 0; i < 16; i++) send_a(8'(i));
        hs_a.in_val = 1'b0;
        check_value("rdy_drop", hs_a.in_rdy, 32'd0);
        check_value("mm_val_flush", hs_a.mm_val, 32'd0);
        step();
        check_value("mm_val_t2", hs_a.mm_val, 32'd1);
        check_value("wr_count_b2b", wr_cnt_a, 32'd16);
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                check_value($sformatf("bank_b2b_k%0d_r%0d", k, r), bank_a[k][r], 32'(4 * r + k));

        // START hold with mm_rdy low; in_data ignored
        snap = wr_cnt_a;
        for (int i = 0; i < 5; i++) begin
            hs_a.in_val = 1'b1;
            in_data_a   = 8'hEE;
            check_value("hold_mm_val", hs_a.mm_val, 32'd1);
            check_value("hold_in_rdy", hs_a.in_rdy, 32'd0);
            step();
        end
        hs_a.in_val = 1'b0;
        check_value("hold_no_wr", wr_cnt_a, 32'(snap));

        // Handshake, first BUSY cycle ignores mm_rdy, 3 low cycles, then release
        hs_a.mm_rdy = 1'b1;
        step();
        check_value("busy_mm_val", hs_a.mm_val, 32'd0);
        check_value("busy_in_rdy0", hs_a.in_rdy, 32'd0);
        step();
        check_value("busy_first_ignored", hs_a.in_rdy, 32'd0);
        hs_a.mm_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("busy_wait_rdy", hs_a.in_rdy, 32'd0);
        end
        hs_a.mm_rdy = 1'b1;
        step();
        hs_a.mm_rdy = 1'b0;
        check_value("reload_in_rdy", hs_a.in_rdy, 32'd1);
        check_value("busy_no_wr", wr_cnt_a, 32'(snap));
        send_a(8'hAA);
        hs_a.in_val = 1'b0;
        @(negedge clk);
        check_value("aa_wren", wren_a, 32'h1);
        check_value("aa_wraddr", wraddr_a, 32'h0);
        check_value("aa_wrdata", wrdata_a[7:0], 32'hAA);

        // Reset beats a simultaneous acceptance
        hs_a.in_val = 1'b1;
        in_data_a   = 8'h99;
        reset       = 1'b1;
        step();
        reset       = 1'b0;
        hs_a.in_val = 1'b0;
        check_value("rst_prio_wren", wren_a, 32'd0);

        // in_val toggled every other cycle
        for (int k = 0; k < 4; k++) for (int r = 0; r < 4; r++) bank_a[k][r] = 8'hFF;
        snap = wr_cnt_a;
        for (int i = 0; i < 16; i++) begin
            hs_a.in_val = 1'b1;
            in_data_a   = 8'(i);
            step();
            hs_a.in_val = 1'b0;
            in_data_a   = 8'hC3;
            step();
        end
        check_value("tog_mm_val", hs_a.mm_val, 32'd1);
        check_value("tog_wr_count", wr_cnt_a - snap, 32'd16);
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                check_value($sformatf("bank_tog_k%0d_r%0d", k, r), bank_a[k][r], 32'(4 * r + k));
        hs_a.mm_rdy = 1'b1;
        step();
        step();
        step();
        hs_a.mm_rdy = 1'b0;
        check_value("tog_reload_rdy", hs_a.in_rdy, 32'd1);

        // Reset after 6 elements abandons the partial matrix
        for (int i = 0; i < 6; i++) send_a(8'(8'h30 + i));
        in_data_a = 8'h77;
        reset     = 1'b1;
        step();
        reset       = 1'b0;
        hs_a.in_val = 1'b0;
        check_value("rst6_wren", wren_a, 32'd0);
        check_value("rst6_wrdata", wrdata_a, 32'd0);
        check_value("rst6_wraddr", wraddr_a, 32'd0);
        check_value("rst6_mm_val", hs_a.mm_val, 32'd0);
        check_value("rst6_in_rdy", hs_a.in_rdy, 32'd1);
        send_a(8'h55);
        hs_a.in_val = 1'b0;
        @(negedge clk);
        check_value("x55_wren", wren_a, 32'h1);
        check_value("x55_wraddr", wraddr_a, 32'h0);
        check_value("x55_wrdata", wrdata_a, 32'h5555_5555);

        // 3x3 instance: non-power-of-two wrap
        step();
        for (int i = 0; i < 9; i++) begin
            if (i == 8) check_value("b_rdy_before_last", hs_b.in_rdy, 32'd1);
            send_b(8'(i));
        end
        hs_b.in_val = 1'b0;
        check_value("b_rdy_drop", hs_b.in_rdy, 32'd0);
        step();
        check_value("b_mm_val", hs_b.mm_val, 32'd1);
        check_value("b_wr_count", wr_cnt_b, 32'd9);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                check_value($sformatf("bank_3x3_k%0d_r%0d", k, r), bank_b[k][r], 32'(3 * r + k));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
